nexys_starship_gc: RTL and testbench
====================================

# nexys_starship_gc

Game controller for Nexys Starship: the driving end of the monster-SM interface. It owns the top-level IDLE/PLAY/OVER flow and drives `play_flag`, per-direction `monster_ctrl` (hold/kill), per-direction spawn pulses and the shared `gameover_ctrl`. It consumes the four monster SMs' presence and gameover flags, and the debounced button pulses. It also keeps the score.

## Interface
- `SPAWN_DIV`, default 4: number of `spawn_tick` pulses per spawn attempt (legal range 1–255).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `Clk`  in  1: system clock.
- `Reset`  in  1: asynchronous, active-low reset (asserted at 0).
- `BtnC`, `BtnU`, `BtnD`, `BtnL`, `BtnR`  in  1 each: debounced single-cycle pulses.
- `spawn_tick`  in  1: single-`Clk`-cycle slow tick enable.
- `monster_sm`  in  4: monster present, bit order {right, left, bottom, top}.
- `monster_gameover`  in  4: per-SM gameover flags, same bit order.
- `play_flag`  out  1: registered; 1 only in PLAY.
- `monster_ctrl`  out  4: combinational hold/kill, fed back to each SM's ctrl input.
- `monster_random`  out  4: registered one-cycle spawn pulses.
- `gameover_ctrl`  out  1: registered; 1 only in OVER.
- `score`  out  8: hits, saturating.
- `q_Idle`, `q_Play`, `q_Over`  out  1 each: one-hot state.

## Operation
- States:
  - IDLE: `BtnC` → PLAY; `score` <= 0 on the same edge.
  - PLAY: any `monster_gameover` bit = 1 → OVER. `BtnC` is ignored.
  - OVER: `BtnC` → IDLE.
  - Illegal encoding → IDLE.
- Direction map: index 0 = top/`BtnU`, 1 = bottom/`BtnD`, 2 = left/`BtnL`, 3 = right/`BtnR`.
- `monster_ctrl[i] = q_Play & monster_sm[i] & ~btn[i]`.
  - The SM copies ctrl each cycle, so a monster survives while ctrl = 1 and is killed on the edge after a press.
  - Outside PLAY, ctrl = 0.
- Hit: `btn[i] & monster_sm[i]` in PLAY.
  - `score` += popcount(hits) that edge, saturating at 255.
  - A press on an empty direction (miss) has no effect.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every `Clk` cycle in all states.
  - Reset value is `LFSR_SEED`.
- Spawn divider:
  - 8-bit counter, increments on `spawn_tick` in PLAY only; cleared in IDLE/OVER.
  - When the counter = `SPAWN_DIV`-1 and `spawn_tick` = 1: wrap to 0 and attempt a spawn with d = `lfsr[1:0]`.
  - `monster_random[d]` <= 1 for exactly one cycle if `monster_sm[d]` = 0. Otherwise no spawn (the attempt is consumed).
  - At most one `monster_random` bit is high at any time.
- Simultaneous events:
  - Gameover in the same cycle as a hit: go to OVER; score not incremented.
  - Gameover in the same cycle as a spawn attempt: no spawn pulse.
  - A spawn attempt on a direction being shot that cycle is suppressed, because `monster_sm[d]` = 1.
- Reset (async, any time):
  - State IDLE.
  - `play_flag`, `gameover_ctrl`, `monster_random`, `score`, divider = 0.
  - LFSR = seed.
  - `monster_ctrl` = 0 (combinational via `q_Play`).

## Timing
- State, `play_flag`, `gameover_ctrl`, `score` and `monster_random` all update on the same `Clk` edge that samples the triggering input: 1-cycle latency.
- `monster_ctrl` is combinational, 0-cycle latency. The SM clears its monster on the next edge.
- `monster_random` pulse: asserted the cycle after the wrapping `spawn_tick`, deasserted the following cycle.
- `gameover_ctrl` stays high throughout OVER. It drops on the edge entering IDLE, so the SMs sit in INIT with `play_flag` = 0 for at least one cycle before PLAY.
- `score` is held through OVER and cleared only on IDLE→PLAY.

## Test plan
- Reset = 0 mid-PLAY with `score` = 5 → state returns to IDLE immediately; all outputs 0. After release, `BtnC` → `q_Play` = 1 and `play_flag` = 1 one cycle later.
- PLAY, `monster_sm` = 4'b0001, no button → `monster_ctrl` = 4'b0001. Pulse `BtnU` → `monster_ctrl` = 0 that cycle, `score` 0→1 next edge. Pulse `BtnD` with `monster_sm[1]` = 0 → `score` unchanged.
- `SPAWN_DIV` = 4, `monster_sm` = 0: four `spawn_tick`s → exactly one `monster_random` one-hot pulse one cycle wide, on bit `lfsr[1:0]`. Repeat with `monster_sm` = 4'b1111 → no pulse.
- `score` = 254; `BtnU` and `BtnL` pulse together with `monster_sm` = 4'b0101 → `score` = 255 (saturates). Another hit → `score` stays 255.
- `monster_gameover` = 4'b0100 in the same cycle as a `BtnU` hit → OVER, `gameover_ctrl` = 1, `play_flag` = 0, `score` unchanged. `BtnC` → IDLE, `gameover_ctrl` = 0. `BtnC` → PLAY, `score` = 0.
- OVER, pulse all direction buttons and `spawn_tick` → `monster_ctrl` = 0, no `monster_random` pulse, `score` constant.

Source files
------------

// File: rtl/nexys_starship_gc.sv
// Purpose : top-level game controller for Nexys Starship (IDLE/PLAY/OVER flow, monster hold/kill, spawning, score).
// Latency : state, play_flag, gameover_ctrl, score, monster_random update on the edge that samples the input; monster_ctrl is combinational.
// Backpress: none; button and tick inputs are single-cycle pulses consumed on the cycle they arrive.
//
// Ports:
//   Clk, Reset (async, active-low)
//   BtnC/U/D/L/R      debounced one-cycle button pulses
//   spawn_tick        slow tick enable, one Clk cycle wide
//   monster_sm[3:0]   monster present per direction {right,left,bottom,top}
//   monster_gameover  per-SM gameover flags, same order
//   play_flag         1 only in PLAY (registered)
//   monster_ctrl      hold(1)/kill(0) fed back to each monster SM (combinational)
//   monster_random    one-cycle spawn pulse per direction (registered)
//   gameover_ctrl     1 only in OVER (registered)
//   score             saturating hit counter
//   q_Idle/q_Play/q_Over  one-hot state view

module nexys_starship_gc #(
    parameter int          SPAWN_DIV = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnC,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       spawn_tick,
    input  logic [3:0] monster_sm,
    input  logic [3:0] monster_gameover,
    output logic       play_flag,
    output logic [3:0] monster_ctrl,
    output logic [3:0] monster_random,
    output logic       gameover_ctrl,
    output logic [7:0] score,
    output logic       q_Idle,
    output logic       q_Play,
    output logic       q_Over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_OVER = 2'b10
    } state_e;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [7:0]  DIV_LAST  = 8'(SPAWN_DIV - 1);

    state_e      state_q, state_d;
    logic        play_flag_q, play_flag_d;
    logic        gameover_q, gameover_d;
    logic [7:0]  score_q, score_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  rand_q, rand_d;

    logic [3:0]  btn;
    logic        in_play;
    logic        any_go;
    logic [3:0]  hit_vec;
    logic [2:0]  hit_cnt;
    logic [8:0]  score_sum;
    logic        wrap;
    logic [1:0]  spawn_dir;
    logic        spawn_ok;

    assign btn     = {BtnR, BtnL, BtnD, BtnU};
    assign in_play = (state_q == S_PLAY);
    assign any_go  = |monster_gameover;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (BtnC)   state_d = S_PLAY;
            S_PLAY:  if (any_go) state_d = S_OVER;
            S_OVER:  if (BtnC)   state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    assign q_Idle = (state_q == S_IDLE);
    assign q_Play = in_play;
    assign q_Over = (state_q == S_OVER);

    // Registered flags track the state being entered, so they change on
    // the same edge as the state itself.
    assign play_flag_d = (state_d == S_PLAY);
    assign gameover_d  = (state_d == S_OVER);

    // A pressed direction drops its hold for this cycle; the SM copies ctrl
    // on the next edge and clears the monster.
    assign monster_ctrl = {4{in_play}} & monster_sm & ~btn;

    // ------------------------------------------------------------------
    // Score: popcount of hits, saturating at 255
    // ------------------------------------------------------------------
    assign hit_vec   = {4{in_play}} & btn & monster_sm;
    assign hit_cnt   = {2'b00, hit_vec[0]} + {2'b00, hit_vec[1]}
                     + {2'b00, hit_vec[2]} + {2'b00, hit_vec[3]};
    assign score_sum = {1'b0, score_q} + {6'b000000, hit_cnt};

    always_comb begin
        score_d = score_q;
        if (q_Idle && BtnC) begin
            score_d = 8'd0;
        end else if (in_play && !any_go) begin
            // Gameover wins over a same-cycle hit.
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        end
    end

    // ------------------------------------------------------------------
    // LFSR: free-running in every state
    // ------------------------------------------------------------------
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    // ------------------------------------------------------------------
    // Spawn divider and spawn pulse
    // ------------------------------------------------------------------
    assign wrap      = in_play && spawn_tick && (div_q == DIV_LAST);
    assign spawn_dir = lfsr_q[1:0];
    // An occupied direction (including one being shot this cycle, which is
    // still present) swallows the attempt; so does a same-cycle gameover.
    assign spawn_ok  = wrap && !any_go && !monster_sm[spawn_dir];

    always_comb begin
        div_d = div_q;
        if (!in_play) begin
            div_d = 8'd0;
        end else if (spawn_tick) begin
            div_d = wrap ? 8'd0 : div_q + 8'd1;
        end
    end

    assign rand_d = spawn_ok ? (4'b0001 << spawn_dir) : 4'b0000;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            play_flag_q <= 1'b0;
            gameover_q  <= 1'b0;
            score_q     <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            div_q       <= 8'd0;
            rand_q      <= 4'b0000;
        end else begin
            play_flag_q <= play_flag_d;
            gameover_q  <= gameover_d;
            score_q     <= score_d;
            lfsr_q      <= lfsr_d;
            div_q       <= div_d;
            rand_q      <= rand_d;
        end
    end

    assign play_flag      = play_flag_q;
    assign gameover_ctrl  = gameover_q;
    assign score          = score_q;
    assign monster_random = rand_q;

endmodule

// File: tb/tb_nexys_starship_gc.sv
// Bench for nexys_starship_gc: directed scenarios followed by randomized play,
// every cycle compared against a behavioural game model.

module tb_nexys_starship_gc;

    localparam int DIV = 4;

    logic       Clk;
    logic       Reset;
    logic       BtnC, BtnU, BtnD, BtnL, BtnR;
    logic       spawn_tick;
    logic [3:0] monster_sm;
    logic [3:0] monster_gameover;
    logic       play_flag;
    logic [3:0] monster_ctrl;
    logic [3:0] monster_random;
    logic       gameover_ctrl;
    logic [7:0] score;
    logic       q_Idle, q_Play, q_Over;

    nexys_starship_gc #(.SPAWN_DIV(DIV), .LFSR_SEED(16'hACE1)) dut (
        .Clk(Clk), .Reset(Reset),
        .BtnC(BtnC), .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
        .spawn_tick(spawn_tick),
        .monster_sm(monster_sm), .monster_gameover(monster_gameover),
        .play_flag(play_flag), .monster_ctrl(monster_ctrl),
        .monster_random(monster_random), .gameover_ctrl(gameover_ctrl),
        .score(score), .q_Idle(q_Idle), .q_Play(q_Play), .q_Over(q_Over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: game state as small integers
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;
    int         m_state = M_IDLE;
    int         m_score = 0;
    int         m_div   = 0;
    int         m_lfsr  = 16'hACE1;
    logic [3:0] m_rand  = 4'b0000;

    logic [3:0] btnv;
    assign btnv = {BtnR, BtnL, BtnD, BtnU};

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_state = M_IDLE;
            m_score = 0;
            m_div   = 0;
            m_lfsr  = 16'hACE1;
            m_rand  = 4'b0000;
        end else begin
            bit         gov;
            int         d;
            logic [3:0] nrand;
            gov   = (monster_gameover != 4'b0000);
            nrand = 4'b0000;
            // spawn attempt, based on the state before this edge
            if (m_state == M_PLAY) begin
                if (spawn_tick) begin
                    if (m_div == DIV - 1) begin
                        m_div = 0;
                        d = m_lfsr % 4;
                        if (!gov && !monster_sm[d]) nrand[d] = 1'b1;
                    end else begin
                        m_div = m_div + 1;
                    end
                end
            end else begin
                m_div = 0;
            end
            // game flow and score
            case (m_state)
                M_IDLE: if (BtnC) begin m_state = M_PLAY; m_score = 0; end
                M_PLAY: begin
                    if (gov) m_state = M_OVER;
                    else begin
                        m_score = m_score + $countones(btnv & monster_sm);
                        if (m_score > 255) m_score = 255;
                    end
                end
                default: if (BtnC) m_state = M_IDLE;
            endcase
            // polynomial step of the LFSR
            if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 16'hB400;
            else                 m_lfsr = m_lfsr / 2;
            m_rand = nrand;
        end
    end

    // Single compare process, half a cycle away from the active edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            logic [3:0] exp_ctrl;
            exp_ctrl = (m_state == M_PLAY) ? (monster_sm & ~btnv) : 4'b0000;
            chk("q_Idle",         q_Idle,         m_state == M_IDLE);
            chk("q_Play",         q_Play,         m_state == M_PLAY);
            chk("q_Over",         q_Over,         m_state == M_OVER);
            chk("play_flag",      play_flag,      m_state == M_PLAY);
            chk("gameover_ctrl",  gameover_ctrl,  m_state == M_OVER);
            chk("score",          score,          m_score);
            chk("monster_random", monster_random, m_rand);
            chk("monster_ctrl",   monster_ctrl,   exp_ctrl);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_in(input logic c, input logic [3:0] b, input logic t,
                          input logic [3:0] s, input logic [3:0] g);
        BtnC = c;
        {BtnR, BtnL, BtnD, BtnU} = b;
        spawn_tick = t;
        monster_sm = s;
        monster_gameover = g;
    endtask

    task automatic tick_clk();
        @(posedge Clk);
        #1;
    endtask

    task automatic step(input logic c, input logic [3:0] b, input logic t,
                        input logic [3:0] s, input logic [3:0] g);
        set_in(c, b, t, s, g);
        tick_clk();
    endtask

    int pulses;
    logic [3:0] pulse_val;

    initial begin
        Reset = 1'b0;
        set_in(1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
        repeat (2) @(posedge Clk);
        #1;
        // reset state
        chk("rst_q_Idle",     q_Idle, 1);
        chk("rst_play_flag",  play_flag, 0);
        chk("rst_gameover",   gameover_ctrl, 0);
        chk("rst_score",      score, 0);
        chk("rst_random",     monster_random, 0);
        chk("rst_ctrl",       monster_ctrl, 0);
        Reset = 1'b1;
        chk_en = 1'b1;
        tick_clk();

        // reach PLAY, score 5, then async reset mid-PLAY
        step(1'b1, 4'h0, 1'b0, 4'h0, 4'h0);
        repeat (5) step(1'b0, 4'b0001, 1'b0, 4'b0001, 4'h0);
        chk("score_five", score, 5);
        set_in(1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
        Reset = 1'b0;
        #1;
        chk("async_rst_idle",  q_Idle, 1);
        chk("async_rst_play",  play_flag, 0);
        chk("async_rst_score", score, 0);
        tick_clk();
        Reset = 1'b1;
        tick_clk();
        step(1'b1, 4'h0, 1'b0, 4'h0, 4'h0);
        chk("restart_q_Play",    q_Play, 1);
        chk("restart_play_flag", play_flag, 1);

        // hold / kill / hit / miss
        set_in(1'b0, 4'h0, 1'b0, 4'b0001, 4'h0);
        #1;
        chk("hold_ctrl", monster_ctrl, 4'b0001);
        tick_clk();
        set_in(1'b0, 4'b0001, 1'b0, 4'b0001, 4'h0);
        #1;
        chk("kill_ctrl", monster_ctrl, 4'b0000);
        tick_clk();
        chk("hit_score", score, 1);
        step(1'b0, 4'b0010, 1'b0, 4'b0001, 4'h0);
        chk("miss_score", score, 1);

        // spawn divider: four ticks into an empty field
        pulses = 0;
        pulse_val = 4'h0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'h0, (k % 2 == 0) && (k < 8), 4'h0, 4'h0);
            if (monster_random != 4'h0) begin
                pulses++;
                pulse_val = monster_random;
            end
        end
        chk("spawn_pulse_count", pulses, 1);
        chk("spawn_onehot", $countones(pulse_val), 1);
        // full field: attempt consumed, no pulse
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'h0, (k % 2 == 0) && (k < 8), 4'hF, 4'h0);
            if (monster_random != 4'h0) pulses++;
        end
        chk("spawn_full_none", pulses, 0);

        // saturation: 1 + 63*4 = 253, +1 = 254
        repeat (63) step(1'b0, 4'hF, 1'b0, 4'hF, 4'h0);
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 4'h0);
        chk("score_254", score, 254);
        step(1'b0, 4'b0101, 1'b0, 4'b0101, 4'h0);
        chk("score_sat", score, 255);
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 4'h0);
        chk("score_sat_hold", score, 255);

        // gameover together with a hit
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0100);
        chk("go_q_Over",     q_Over, 1);
        chk("go_ctrl_flag",  gameover_ctrl, 1);
        chk("go_play_flag",  play_flag, 0);
        chk("go_score",      score, 255);

        // OVER ignores direction buttons and ticks
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            set_in(1'b0, 4'hF, 1'b1, 4'hF, 4'h0);
            #1;
            chk("over_ctrl", monster_ctrl, 0);
            tick_clk();
            if (monster_random != 4'h0) pulses++;
        end
        chk("over_no_spawn", pulses, 0);
        chk("over_score", score, 255);

        step(1'b1, 4'h0, 1'b0, 4'h0, 4'h0);
        chk("over_to_idle", q_Idle, 1);
        chk("idle_gameover_low", gameover_ctrl, 0);
        step(1'b1, 4'h0, 1'b0, 4'h0, 4'h0);
        chk("idle_to_play", q_Play, 1);
        chk("play_score_clr", score, 0);

        // randomized play against the model
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] b, s, g;
            b = 4'h0;
            for (int i = 0; i < 4; i++) b[i] = ($urandom_range(0, 3) == 0);
            s = 4'($urandom);
            g = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            set_in($urandom_range(0, 15) == 0, b, $urandom_range(0, 1) == 1, s, g);
            if ($urandom_range(0, 399) == 0) Reset = 1'b0;
            tick_clk();
            Reset = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
